gpc_c2f_arb: RTL and testbench
==============================

Name: gpc_c2f_arb

Overview:
- Shares the single core-to-fabric (C2F) request channel of gpc_4t between its 4 hardware threads.
- Each thread posts at most one fabric request (read or write) and receives its response routed back by thread ID.
- Sits between the thread pipeline's non-local memory access path and the gpc_4t C2F_Req*/C2F_Rsp* ports.
- Round-robin grant; honours C2F_RspStall back-pressure.

Parameters:
- NUM_THR, 4, number of hardware threads (ThreadID width = 2).
- ADDR_W, 32, request address width.
- DATA_W, 32, request/response data width.
- TO_CYC, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- QClk  in  1  core clock
- RstQnnnL  in  1  asynchronous active-low reset
- ThrReqValid  in  NUM_THR  per-thread request valid
- ThrReqOpcode  in  NUM_THR x 2  per-thread opcode (RD/WR)
- ThrReqAddress  in  NUM_THR x ADDR_W  per-thread address
- ThrReqData  in  NUM_THR x DATA_W  per-thread write data
- ThrReqReady  out  NUM_THR  thread may hand off a request (state IDLE)
- ThrRspValid  out  NUM_THR  one-cycle response pulse per thread
- ThrRspData  out  DATA_W  response data (shared bus, qualified by ThrRspValid)
- C2F_ReqValidQ500H  out  1  fabric request valid
- C2F_ReqOpcodeQ500H  out  2  fabric opcode
- C2F_ReqThreadIDQ500H  out  2  granted thread
- C2F_ReqAddressQ500H  out  ADDR_W  fabric address
- C2F_ReqDataQ500H  out  DATA_W  fabric write data
- C2F_RspValidQ502H  in  1  fabric response valid
- C2F_RspOpcodeQ502H  in  2  RD_RSP/WR_RSP
- C2F_RspThreadIDQ502H  in  2  response owner
- C2F_RspDataQ502H  in  DATA_W  read data
- C2F_RspStall  in  1  fabric cannot accept a request this cycle
- ArbErr  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, RstQnnnL=0):
  - All thread FSMs return to IDLE; RR pointer = 0.
  - All outputs 0 except ThrReqReady = all-ones.
  - A reset mid-transaction drops in-flight requests; late responses arriving after reset raise ArbErr.
- Per-thread FSM: IDLE -> WAIT_GNT -> WAIT_RSP -> IDLE.
  - ThrReqReady[i] = (state==IDLE).
  - Handshake ThrReqValid&ThrReqReady in cycle N: opcode/addr/data latched into the thread slot; state WAIT_GNT in N+1.
- Grant:
  - The output register is free if C2F_ReqValidQ500H==0, or ==1 with C2F_RspStall==0 (accepted).
  - When free, pick the first WAIT_GNT thread starting at the RR pointer.
  - The slot is loaded into the output registers the next cycle. Thread -> WAIT_RSP; pointer = grantee+1 mod NUM_THR.
  - Minimum latency: handshake in N, C2F_ReqValidQ500H high in N+2.
  - While C2F_RspStall=1 with a valid output, all C2F_Req* outputs hold stable and no new grant occurs.
  - Back-to-back grants are allowed: 1 request per cycle with no stall.
- Response:
  - C2F_RspValidQ502H in cycle M for thread t in WAIT_RSP gives ThrRspValid[t]=1 and ThrRspData=C2F_RspDataQ502H in M+1; thread t is IDLE in M+1.
  - The thread may re-request in M+1.
  - A response with a grant in the same cycle is legal (independent threads).
  - A response may arrive in the same cycle its request is accepted, but never earlier.
- Errors: ArbErr is set and held until reset on either of:
  - response for a thread not in WAIT_RSP (response is dropped);
  - opcode mismatch (RD_RSP for a WR, or the reverse).
- ThrReqValid to a thread not in IDLE is ignored (not an error).

Optional Feature:
- Macro: LOTR_C2F_TIMEOUT_EN.
- Defined:
  - Per-thread counter runs in WAIT_RSP.
  - Reaching TO_CYC sets ArbErr, forces the thread to IDLE, and emits ThrRspValid with data 32'hDEAD_BEEF.
  - A later response for that thread is treated as unexpected.
- Undefined: no counters; threads wait indefinitely.

Decomposition:
- Shared package lotr_pkg:
  - typedef t_c2f_opcode enum {RD=2'b00, WR=2'b01, RD_RSP=2'b10, WR_RSP=2'b11};
  - typedef t_thr_st {IDLE, WAIT_GNT, WAIT_RSP};
  - struct t_c2f_req {opcode, address, data};
  - constant C2F_TO_DATA.
- One sub-module: gpc_rr_arb, a NUM_THR-way round-robin picker (request vector, pointer -> one-hot grant, valid).

Test Plan:
- Single read:
  - Stimulus: thread 2 RD addr 32'h0040_0100 in cycle 10; fabric responds RD_RSP data 32'h1234_5678 in cycle 15.
  - Required: C2F_ReqValid in cycle 12 with ThreadID=2; ThrRspValid[2] in 16 with data 32'h1234_5678; ThrReqReady[2] back to 1 in 16.
- All 4 threads request in the same cycle, no stall:
  - Required: grants on consecutive cycles in order 0,1,2,3.
  - Second round, with thread 1 re-requesting first: RR pointer=0, thread 1 granted.
- Stall:
  - Stimulus: thread 0 WR 32'hA5A5_0001 @ 32'h0040_0000; C2F_RspStall=1 for 5 cycles.
  - Required: outputs stable for all 5 cycles; no thread 3 grant until 1 cycle after stall drops.
- Unexpected response:
  - Stimulus: RspValid for thread 3 while it is IDLE.
  - Required: ArbErr=1 next cycle; no ThrRspValid.
  - Opcode mismatch (WR_RSP for an outstanding RD): ArbErr=1.
- Reset mid-flight:
  - Stimulus: assert RstQnnnL=0 while threads 1 and 2 are in WAIT_RSP.
  - Required: all outputs 0 asynchronously; ThrReqReady=4'hF after release.
- LOTR_C2F_TIMEOUT_EN with TO_CYC=16:
  - Stimulus: no response to thread 1.
  - Required: ArbErr and ThrRspValid[1] with data 32'hDEAD_BEEF exactly 16 cycles after WAIT_RSP entry.

Source files
------------

// File: rtl/lotr_pkg.sv
// lotr_pkg: shared types and constants for the gpc_4t core-to-fabric path.
//   t_c2f_opcode : fabric request/response opcodes
//   t_thr_st     : per-thread C2F request state
//   t_c2f_req    : one latched thread request (opcode, address, data)
//   C2F_TO_DATA  : response data returned to a thread whose request timed out
//   rsp_opc_for  : response opcode that legally answers a given request opcode
package lotr_pkg;

    localparam int C2F_ADDR_W = 32;
    localparam int C2F_DATA_W = 32;

    localparam logic [C2F_DATA_W-1:0] C2F_TO_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        RD     = 2'b00,
        WR     = 2'b01,
        RD_RSP = 2'b10,
        WR_RSP = 2'b11
    } t_c2f_opcode;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_GNT = 2'b01,
        WAIT_RSP = 2'b10
    } t_thr_st;

    typedef struct packed {
        t_c2f_opcode             opcode;
        logic [C2F_ADDR_W-1:0]   address;
        logic [C2F_DATA_W-1:0]   data;
    } t_c2f_req;

    function automatic logic [1:0] rsp_opc_for(input t_c2f_opcode op);
        return (op == WR) ? WR_RSP : RD_RSP;
    endfunction

endpackage

// File: rtl/gpc_rr_arb.sv
// gpc_rr_arb: N-way round-robin picker (purely combinational).
//   req     : request vector, one bit per requester
//   ptr     : highest-priority index for this decision
//   gnt     : one-hot grant (zero when nothing requests)
//   gnt_idx : binary index of the granted requester
//   gnt_vld : at least one request was present
module gpc_rr_arb #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    int idx;

    // Scan from ptr upwards with wrap; the first requester found wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_vld && req[idx]) begin
                gnt_vld      = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/gpc_c2f_arb.sv
// gpc_c2f_arb: shares the gpc_4t C2F request channel between NUM_THR threads.
// Optional feature macro: LOTR_C2F_TIMEOUT_EN (per-thread response watchdog of
// TO_CYC cycles; on expiry the thread is released with data C2F_TO_DATA).
//
// Ports
//   QClk, RstQnnnL                 : clock, async active-low reset
//   ThrReq{Valid,Opcode,Address,Data} / ThrReqReady : per-thread request in
//   ThrRspValid, ThrRspData        : per-thread response pulse, shared data bus
//   C2F_Req*Q500H                  : registered fabric request
//   C2F_Rsp*Q502H, C2F_RspStall    : fabric response and request back-pressure
//   ArbErr                         : sticky protocol error
//   dbg_thr_st                     : per-thread FSM state (t_thr_st encoding)
//
// Handshakes: a thread request transfers in a cycle where ThrReqValid[i] and
// ThrReqReady[i] are both 1. A fabric request transfers in a cycle where
// C2F_ReqValidQ500H is 1 and C2F_RspStall is 0; until then every C2F_Req*
// output holds. Responses are pulses with no back-pressure.
import lotr_pkg::*;

module gpc_c2f_arb #(
    parameter int NUM_THR = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TO_CYC  = 1024
) (
    input  logic                            QClk,
    input  logic                            RstQnnnL,
    input  logic [NUM_THR-1:0]              ThrReqValid,
    input  logic [NUM_THR-1:0][1:0]         ThrReqOpcode,
    input  logic [NUM_THR-1:0][ADDR_W-1:0]  ThrReqAddress,
    input  logic [NUM_THR-1:0][DATA_W-1:0]  ThrReqData,
    output logic [NUM_THR-1:0]              ThrReqReady,
    output logic [NUM_THR-1:0]              ThrRspValid,
    output logic [DATA_W-1:0]               ThrRspData,
    output logic                            C2F_ReqValidQ500H,
    output logic [1:0]                      C2F_ReqOpcodeQ500H,
    output logic [$clog2(NUM_THR)-1:0]      C2F_ReqThreadIDQ500H,
    output logic [ADDR_W-1:0]               C2F_ReqAddressQ500H,
    output logic [DATA_W-1:0]               C2F_ReqDataQ500H,
    input  logic                            C2F_RspValidQ502H,
    input  logic [1:0]                      C2F_RspOpcodeQ502H,
    input  logic [$clog2(NUM_THR)-1:0]      C2F_RspThreadIDQ502H,
    input  logic [DATA_W-1:0]               C2F_RspDataQ502H,
    input  logic                            C2F_RspStall,
    output logic                            ArbErr,
    output logic [NUM_THR-1:0][1:0]         dbg_thr_st
);

    localparam int TID_W = $clog2(NUM_THR);

    t_thr_st              thr_st     [NUM_THR];
    t_thr_st              thr_st_nxt [NUM_THR];
    t_c2f_req             slot       [NUM_THR];
    logic [TID_W-1:0]     rr_ptr;

    logic [NUM_THR-1:0]   gnt_req;
    logic [NUM_THR-1:0]   gnt_oh;
    logic [TID_W-1:0]     gnt_idx;
    logic                 gnt_vld;
    logic                 out_free;
    logic                 grant_en;

    logic [NUM_THR-1:0]   rsp_hit;
    logic [NUM_THR-1:0]   rsp_ok;
    logic                 rsp_unexp;
    logic                 rsp_opc_bad;
    logic [NUM_THR-1:0]   to_fire;

    // Output register may take a new request when empty or being accepted now.
    assign out_free = !C2F_ReqValidQ500H || !C2F_RspStall;
    assign grant_en = out_free && gnt_vld;

    always_comb begin
        for (int i = 0; i < NUM_THR; i++) begin
            gnt_req[i]     = (thr_st[i] == WAIT_GNT);
            ThrReqReady[i] = (thr_st[i] == IDLE);
            dbg_thr_st[i]  = thr_st[i];
            rsp_hit[i]     = C2F_RspValidQ502H && (C2F_RspThreadIDQ502H == TID_W'(i));
        end
    end

    gpc_rr_arb #(
        .N  (NUM_THR),
        .IW (TID_W)
    ) u_rr_arb (
        .req     (gnt_req),
        .ptr     (rr_ptr),
        .gnt     (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

`ifdef LOTR_C2F_TIMEOUT_EN
    localparam int CNT_W = $clog2(TO_CYC + 1);

    logic [CNT_W-1:0] to_cnt [NUM_THR];

    // Counter is 0 on the WAIT_RSP entry cycle, so expiry is decided when it
    // reads TO_CYC-1 and the registered pulse lands exactly TO_CYC cycles
    // after entry. A fabric response in that cycle owns the shared data bus,
    // so expiry waits one cycle (the counter saturates instead of wrapping).
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            for (int i = 0; i < NUM_THR; i++) to_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_THR; i++) begin
                if (thr_st[i] != WAIT_RSP)
                    to_cnt[i] <= '0;
                else if (to_cnt[i] != '1)
                    to_cnt[i] <= to_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_THR; i++)
            to_fire[i] = (thr_st[i] == WAIT_RSP) && (to_cnt[i] >= CNT_W'(TO_CYC - 1))
                         && !C2F_RspValidQ502H;
    end
`else
    assign to_fire = '0;
`endif

    // Per-thread next state plus response classification.
    always_comb begin
        rsp_ok      = '0;
        rsp_unexp   = 1'b0;
        rsp_opc_bad = 1'b0;
        for (int i = 0; i < NUM_THR; i++) begin
            thr_st_nxt[i] = thr_st[i];
            case (thr_st[i])
                IDLE: begin
                    if (ThrReqValid[i]) thr_st_nxt[i] = WAIT_GNT;
                end
                WAIT_GNT: begin
                    if (grant_en && gnt_oh[i]) thr_st_nxt[i] = WAIT_RSP;
                end
                WAIT_RSP: begin
                    if (rsp_hit[i]) begin
                        rsp_ok[i]     = 1'b1;
                        thr_st_nxt[i] = IDLE;
                        if (C2F_RspOpcodeQ502H != rsp_opc_for(slot[i].opcode))
                            rsp_opc_bad = 1'b1;
                    end else if (to_fire[i]) begin
                        thr_st_nxt[i] = IDLE;
                    end
                end
                default: thr_st_nxt[i] = IDLE;
            endcase
            // Responses for threads not waiting on one are dropped.
            if (rsp_hit[i] && (thr_st[i] != WAIT_RSP)) rsp_unexp = 1'b1;
        end
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            for (int i = 0; i < NUM_THR; i++) begin
                thr_st[i] <= IDLE;
                slot[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_THR; i++) begin
                thr_st[i] <= thr_st_nxt[i];
                if (ThrReqValid[i] && (thr_st[i] == IDLE)) begin
                    slot[i].opcode  <= t_c2f_opcode'(ThrReqOpcode[i]);
                    slot[i].address <= C2F_ADDR_W'(ThrReqAddress[i]);
                    slot[i].data    <= C2F_DATA_W'(ThrReqData[i]);
                end
            end
        end
    end

    // Fabric request register and round-robin pointer.
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            C2F_ReqValidQ500H    <= 1'b0;
            C2F_ReqOpcodeQ500H   <= '0;
            C2F_ReqThreadIDQ500H <= '0;
            C2F_ReqAddressQ500H  <= '0;
            C2F_ReqDataQ500H     <= '0;
            rr_ptr               <= '0;
        end else if (out_free) begin
            C2F_ReqValidQ500H <= gnt_vld;
            if (gnt_vld) begin
                C2F_ReqOpcodeQ500H   <= slot[gnt_idx].opcode;
                C2F_ReqThreadIDQ500H <= gnt_idx;
                C2F_ReqAddressQ500H  <= ADDR_W'(slot[gnt_idx].address);
                C2F_ReqDataQ500H     <= DATA_W'(slot[gnt_idx].data);
                rr_ptr <= (int'(gnt_idx) == NUM_THR - 1) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Thread responses and sticky error.
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            ThrRspValid <= '0;
            ThrRspData  <= '0;
            ArbErr      <= 1'b0;
        end else begin
            ThrRspValid <= rsp_ok | to_fire;
            if (|rsp_ok)
                ThrRspData <= C2F_RspDataQ502H;
            else if (|to_fire)
                ThrRspData <= DATA_W'(C2F_TO_DATA);
            ArbErr <= ArbErr | rsp_unexp | rsp_opc_bad | (|to_fire);
        end
    end

endmodule

// File: tb/tb_gpc_c2f_arb.sv
// tb_gpc_c2f_arb: directed bench for gpc_c2f_arb. Inputs change 1 time unit
// after the rising edge and outputs are checked at that same point.
import lotr_pkg::*;

module tb_gpc_c2f_arb;

    localparam int NT = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NT-1:0]          req_v;
    logic [NT-1:0][1:0]     req_op;
    logic [NT-1:0][AW-1:0]  req_a;
    logic [NT-1:0][DW-1:0]  req_d;
    logic [NT-1:0]          req_rdy;
    logic [NT-1:0]          rsp_v;
    logic [DW-1:0]          rsp_d;
    logic                   c_req_v;
    logic [1:0]             c_req_op;
    logic [1:0]             c_req_tid;
    logic [AW-1:0]          c_req_a;
    logic [DW-1:0]          c_req_d;
    logic                   c_rsp_v;
    logic [1:0]             c_rsp_op;
    logic [1:0]             c_rsp_tid;
    logic [DW-1:0]          c_rsp_d;
    logic                   c_stall;
    logic                   arb_err;
    logic [NT-1:0][1:0]     dbg_st;

    gpc_c2f_arb #(
        .NUM_THR (NT),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TO_CYC  (16)
    ) dut (
        .QClk                 (clk),
        .RstQnnnL             (rst_n),
        .ThrReqValid          (req_v),
        .ThrReqOpcode         (req_op),
        .ThrReqAddress        (req_a),
        .ThrReqData           (req_d),
        .ThrReqReady          (req_rdy),
        .ThrRspValid          (rsp_v),
        .ThrRspData           (rsp_d),
        .C2F_ReqValidQ500H    (c_req_v),
        .C2F_ReqOpcodeQ500H   (c_req_op),
        .C2F_ReqThreadIDQ500H (c_req_tid),
        .C2F_ReqAddressQ500H  (c_req_a),
        .C2F_ReqDataQ500H     (c_req_d),
        .C2F_RspValidQ502H    (c_rsp_v),
        .C2F_RspOpcodeQ502H   (c_rsp_op),
        .C2F_RspThreadIDQ502H (c_rsp_tid),
        .C2F_RspDataQ502H     (c_rsp_d),
        .C2F_RspStall         (c_stall),
        .ArbErr               (arb_err),
        .dbg_thr_st           (dbg_st)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int t, input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        req_v[t]  = 1'b1;
        req_op[t] = op;
        req_a[t]  = a;
        req_d[t]  = d;
    endtask

    task automatic rsp(input int t, input logic [1:0] op, input logic [DW-1:0] d);
        c_rsp_v   = 1'b1;
        c_rsp_tid = 2'(t);
        c_rsp_op  = op;
        c_rsp_d   = d;
    endtask

    task automatic rsp_clear();
        c_rsp_v   = 1'b0;
        c_rsp_tid = '0;
        c_rsp_op  = '0;
        c_rsp_d   = '0;
    endtask

    task automatic chk_req(input string tag, input int tid, input logic [1:0] op,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        check({tag, "_vld"}, 64'(c_req_v), 64'd1);
        check({tag, "_tid"}, 64'(c_req_tid), 64'(tid));
        check({tag, "_op"}, 64'(c_req_op), 64'(op));
        check({tag, "_addr"}, 64'(c_req_a), 64'(a));
        check({tag, "_data"}, 64'(c_req_d), 64'(d));
    endtask

    // Expects a response pulse on thread t carrying the head of exp_q.
    task automatic chk_rsp(input string tag, input int t);
        logic [DW-1:0] e;
        logic [NT-1:0] oh;
        oh = '0;
        oh[t] = 1'b1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
        check({tag, "_vld"}, 64'(rsp_v), 64'(oh));
        check({tag, "_data"}, 64'(rsp_d), 64'(e));
        check({tag, "_rdy"}, 64'(req_rdy[t]), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n   = 1'b0;
        req_v   = '0;
        req_op  = '0;
        req_a   = '0;
        req_d   = '0;
        c_stall = 1'b0;
        rsp_clear();

        #12;
        check("rst_c2f_vld", 64'(c_req_v), 64'd0);
        check("rst_c2f_addr", 64'(c_req_a), 64'd0);
        check("rst_rdy", 64'(req_rdy), 64'hF);
        check("rst_rsp_vld", 64'(rsp_v), 64'd0);
        check("rst_err", 64'(arb_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // All four threads at once: grants 0,1,2,3 back-to-back.
        for (int i = 0; i < NT; i++) post(i, RD, 32'h1000_0000 + 32'(i * 16), '0);
        step();
        req_v = '0;
        check("all4_st", 64'(dbg_st), 64'h55);
        check("all4_rdy", 64'(req_rdy), 64'h0);
        for (int i = 0; i < NT; i++) begin
            step();
            chk_req($sformatf("all4_g%0d", i), i, RD, 32'h1000_0000 + 32'(i * 16), '0);
        end
        step();
        check("all4_idle_vld", 64'(c_req_v), 64'd0);
        for (int i = 0; i < NT; i++) begin
            rsp(i, RD_RSP, 32'hD000_0000 + 32'(i));
            exp_q.push_back(32'hD000_0000 + 32'(i));
            step();
            rsp_clear();
            chk_rsp($sformatf("all4_r%0d", i), i);
        end

        // Pointer is back at 0: a lone thread 1 request is granted; its
        // response arrives in the very cycle the fabric accepts it.
        post(1, WR, 32'h2000_0004, 32'hCAFE_0001);
        step();
        req_v = '0;
        step();
        chk_req("t1", 1, WR, 32'h2000_0004, 32'hCAFE_0001);
        rsp(1, WR_RSP, 32'h0);
        exp_q.push_back(32'h0);
        step();
        rsp_clear();
        chk_rsp("t1_r", 1);
        check("t1_err", 64'(arb_err), 64'd0);

        // Pointer is 2: threads 0 and 3 together -> 3 first, then 0.
        post(0, RD, 32'h3000_0000, '0);
        post(3, RD, 32'h3000_0030, '0);
        step();
        req_v = '0;
        step();
        chk_req("p2_g3", 3, RD, 32'h3000_0030, '0);
        step();
        chk_req("p2_g0", 0, RD, 32'h3000_0000, '0);
        rsp(3, RD_RSP, 32'h0303_0303);
        exp_q.push_back(32'h0303_0303);
        step();
        chk_rsp("p2_r3", 3);
        rsp(0, RD_RSP, 32'h0000_1111);
        exp_q.push_back(32'h0000_1111);
        step();
        rsp_clear();
        chk_rsp("p2_r0", 0);

        // Single read on thread 2: request at N+2, response pulse at M+1.
        post(2, RD, 32'h0040_0100, '0);
        step();
        req_v = '0;
        check("rd_rdy_lo", 64'(req_rdy[2]), 64'd0);
        check("rd_early_vld", 64'(c_req_v), 64'd0);
        step();
        chk_req("rd", 2, RD, 32'h0040_0100, '0);
        step();
        check("rd_vld_drop", 64'(c_req_v), 64'd0);
        step();
        step();
        rsp(2, RD_RSP, 32'h1234_5678);
        exp_q.push_back(32'h1234_5678);
        step();
        rsp_clear();
        chk_rsp("rd_r", 2);
        check("rd_rdy_all", 64'(req_rdy), 64'hF);
        step();
        check("rd_pulse_1cyc", 64'(rsp_v), 64'd0);

        // Stall: thread 0 write held for 5 stall cycles, thread 3 waits.
        post(0, WR, 32'h0040_0000, 32'hA5A5_0001);
        step();
        req_v = '0;
        step();
        chk_req("st_g0", 0, WR, 32'h0040_0000, 32'hA5A5_0001);
        c_stall = 1'b1;
        post(3, RD, 32'h0040_0300, '0);
        for (int k = 1; k <= 5; k++) begin
            step();
            req_v = '0;
            chk_req($sformatf("st_hold%0d", k), 0, WR, 32'h0040_0000, 32'hA5A5_0001);
            if (k == 5) c_stall = 1'b0;
        end
        step();
        chk_req("st_g3", 3, RD, 32'h0040_0300, '0);
        rsp(0, WR_RSP, 32'h0);
        exp_q.push_back(32'h0);
        step();
        rsp_clear();
        chk_rsp("st_r0", 0);
        check("st_err_clean", 64'(arb_err), 64'd0);

        // Opcode mismatch: WR_RSP answering thread 3's outstanding read.
        rsp(3, WR_RSP, 32'h7777_7777);
        step();
        rsp_clear();
        check("opc_err", 64'(arb_err), 64'd1);
        step();
        check("opc_err_sticky", 64'(arb_err), 64'd1);

        do_reset();
        check("rst2_err", 64'(arb_err), 64'd0);

        // Unexpected response for idle thread 3.
        rsp(3, RD_RSP, 32'h5555_5555);
        step();
        rsp_clear();
        check("unexp_err", 64'(arb_err), 64'd1);
        check("unexp_rsp_vld", 64'(rsp_v), 64'd0);

        // Reset while threads 1 and 2 are waiting for responses.
        post(1, RD, 32'h0050_0010, '0);
        post(2, WR, 32'h0050_0020, 32'h2222_2222);
        step();
        req_v = '0;
        step();
        chk_req("mf_g1", 1, RD, 32'h0050_0010, '0);
        step();
        chk_req("mf_g2", 2, WR, 32'h0050_0020, 32'h2222_2222);
        check("mf_st", 64'(dbg_st), 64'h28);
        #2;
        rst_n = 1'b0;
        #1;
        check("mf_async_vld", 64'(c_req_v), 64'd0);
        check("mf_async_tid", 64'(c_req_tid), 64'd0);
        check("mf_async_addr", 64'(c_req_a), 64'd0);
        check("mf_async_data", 64'(c_req_d), 64'd0);
        check("mf_async_op", 64'(c_req_op), 64'd0);
        check("mf_async_err", 64'(arb_err), 64'd0);
        check("mf_async_rdy", 64'(req_rdy), 64'hF);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("mf_rdy", 64'(req_rdy), 64'hF);
        rsp(1, RD_RSP, 32'h1111_1111);
        step();
        rsp_clear();
        check("mf_late_err", 64'(arb_err), 64'd1);
        check("mf_late_vld", 64'(rsp_v), 64'd0);

`ifdef LOTR_C2F_TIMEOUT_EN
        do_reset();
        post(1, RD, 32'h0060_0000, '0);
        step();
        req_v = '0;
        step();
        chk_req("to_g1", 1, RD, 32'h0060_0000, '0);
        for (int k = 1; k < 16; k++) begin
            step();
            check($sformatf("to_quiet%0d", k), 64'({arb_err, rsp_v}), 64'd0);
        end
        step();
        exp_q.push_back(32'hDEAD_BEEF);
        chk_rsp("to_fire", 1);
        check("to_err", 64'(arb_err), 64'd1);
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
